// File: rtl/ise_pkg.sv
// rtl/ise_pkg.sv - constants, color codes and host state encoding shared by the ise_host slice
package ise_pkg;

    localparam int PIX_PER_IMG     = 16384;
    localparam int NUM_IMG         = 32;
    localparam int COLLECT_TIMEOUT = 1023;

    localparam int PIX_W  = 14;
    localparam int IMG_W  = 5;
    localparam int RGB_W  = 24;
    localparam int COL_W  = 2;
    localparam int SLOT_W = COL_W + IMG_W;
    localparam int TMO_W  = 10;

    typedef enum logic [COL_W-1:0] {
        COLOR_R = 2'd0,
        COLOR_G = 2'd1,
        COLOR_B = 2'd2
    } color_t;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_PREFETCH = 3'd1,
        ST_STREAM   = 3'd2,
        ST_GAP      = 3'd3,
        ST_COLLECT  = 3'd4,
        ST_DONE     = 3'd5
    } host_state_t;

endpackage

// File: rtl/ise_host_result_buf.sv
// rtl/ise_host_result_buf.sv - 32 x {color, index} result registers, one write port, combinational read
module ise_host_result_buf
    import ise_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              i_wr_en,
    input  logic [IMG_W-1:0]  i_wr_addr,
    input  logic [SLOT_W-1:0] i_wr_data,
    input  logic [IMG_W-1:0]  i_rd_addr,
    output logic [SLOT_W-1:0] o_rd_data
);

    logic [SLOT_W-1:0] r_mem [NUM_IMG];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_IMG; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_addr] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_addr];

endmodule

// File: rtl/ise_host.sv
// rtl/ise_host.sv - streams 32 ROM images into the engine and collects its results; ISE_HOST_CHECK_EN adds index checking
module ise_host
    import ise_pkg::*;
#(
    parameter int PIXELS = PIX_PER_IMG
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    output logic [IMG_W+PIX_W-1:0] mem_addr,
    input  logic [RGB_W-1:0]       mem_rdata,
    output logic                   ise_rst,
    output logic [IMG_W-1:0]       image_in_index,
    output logic [RGB_W-1:0]       pixel_in,
    input  logic                   busy,
    input  logic                   out_valid,
    input  logic [COL_W-1:0]       color_index,
    input  logic [IMG_W-1:0]       image_out_index,
    input  logic [IMG_W-1:0]       rd_addr,
    output logic [COL_W-1:0]       rd_color,
    output logic [IMG_W-1:0]       rd_index,
    output logic                   done,
    output logic                   sync_err,
    output logic                   timeout_err,
    output logic                   dup_err
);

    localparam logic [PIX_W-1:0] PIX_LAST = PIX_W'(PIXELS - 1);
    // The fetch address pauses once per image so the next image's pixel 0 lands right after GAP.
    localparam logic [PIX_W-1:0] PIX_HOLD = PIX_W'(PIXELS - 3);
    localparam logic [IMG_W-1:0] IMG_LAST = IMG_W'(NUM_IMG - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(COLLECT_TIMEOUT - 1);

    host_state_t       r_state;
    host_state_t       w_next;
    logic              r_pre_phase;
    logic [IMG_W-1:0]  r_fetch_img;
    logic [PIX_W-1:0]  r_fetch_pix;
    logic [PIX_W-1:0]  r_pix_cnt;
    logic [IMG_W-1:0]  r_img;
    logic [RGB_W-1:0]  r_pixel;
    logic              r_ise_rst;
    logic              r_sync_err;
    logic              r_tmo_err;
    logic [TMO_W-1:0]  r_tmo_cnt;
    logic [IMG_W-1:0]  r_slot;

    logic              w_start;
    logic              w_wr_en;
    logic              w_timeout;
    logic              w_busy_bad;
    logic              w_load_pix;
    logic              w_fetch_adv;
    logic              w_last_img;
    logic [SLOT_W-1:0] w_rd_data;

    always_comb begin
        w_next      = r_state;
        w_start     = 1'b0;
        w_wr_en     = 1'b0;
        w_timeout   = 1'b0;
        w_busy_bad  = 1'b0;
        w_load_pix  = 1'b0;
        w_fetch_adv = 1'b0;
        w_last_img  = (r_img == IMG_LAST);
        unique case (r_state)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    w_start = 1'b1;
                    w_next  = ST_PREFETCH;
                end
            end
            ST_PREFETCH: begin
                w_fetch_adv = 1'b1;
                w_load_pix  = r_pre_phase;
                if (r_pre_phase) begin
                    w_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_busy_bad  = busy;
                w_load_pix  = 1'b1;
                w_fetch_adv = (r_pix_cnt != PIX_HOLD);
                if (r_pix_cnt == PIX_LAST) begin
                    w_next = ST_GAP;
                end
            end
            ST_GAP: begin
                w_busy_bad  = !busy;
                w_fetch_adv = 1'b1;
                w_load_pix  = !w_last_img;
                w_next      = w_last_img ? ST_COLLECT : ST_STREAM;
            end
            ST_COLLECT: begin
                w_wr_en   = out_valid;
                w_timeout = !out_valid && (r_tmo_cnt == TMO_LAST);
                if ((out_valid && (r_slot == IMG_LAST)) || w_timeout) begin
                    w_next = ST_DONE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_ise_rst <= 1'b1;
        end else begin
            r_state   <= w_next;
            r_ise_rst <= (w_next == ST_IDLE) || (w_next == ST_PREFETCH) || (w_next == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_img <= '0;
            r_fetch_pix <= '0;
        end else if (w_start) begin
            r_fetch_img <= '0;
            r_fetch_pix <= '0;
        end else if (w_fetch_adv) begin
            if (r_fetch_pix == PIX_LAST) begin
                r_fetch_pix <= '0;
                if (r_fetch_img != IMG_LAST) begin
                    r_fetch_img <= r_fetch_img + 1'b1;
                end
            end else begin
                r_fetch_pix <= r_fetch_pix + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pre_phase <= 1'b0;
            r_pix_cnt   <= '0;
            r_img       <= '0;
            r_pixel     <= '0;
        end else begin
            r_pre_phase <= (r_state == ST_PREFETCH) && !r_pre_phase;
            if (w_start) begin
                r_pix_cnt <= '0;
                r_img     <= '0;
            end else begin
                if (r_state == ST_STREAM) begin
                    r_pix_cnt <= (r_pix_cnt == PIX_LAST) ? '0 : r_pix_cnt + 1'b1;
                end
                if ((r_state == ST_GAP) && !w_last_img) begin
                    r_img <= r_img + 1'b1;
                end
            end
            if (w_load_pix) begin
                r_pixel <= mem_rdata;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync_err <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_tmo_cnt  <= '0;
            r_slot     <= '0;
        end else if (w_start) begin
            r_sync_err <= 1'b0;
            r_tmo_err  <= 1'b0;
            r_tmo_cnt  <= '0;
            r_slot     <= '0;
        end else begin
            if (w_busy_bad) begin
                r_sync_err <= 1'b1;
            end
            if (w_timeout) begin
                r_tmo_err <= 1'b1;
            end
            // Silence is measured from COLLECT entry or from the most recent result.
            if (r_state == ST_COLLECT) begin
                r_tmo_cnt <= out_valid ? '0 : r_tmo_cnt + 1'b1;
            end
            if (w_wr_en) begin
                r_slot <= r_slot + 1'b1;
            end
        end
    end

`ifdef ISE_HOST_CHECK_EN
    logic [NUM_IMG-1:0] r_seen;
    logic [NUM_IMG-1:0] w_seen_next;
    logic               r_dup_err;

    always_comb begin
        w_seen_next = r_seen;
        if (w_wr_en) begin
            w_seen_next[image_out_index] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_seen    <= '0;
            r_dup_err <= 1'b0;
        end else if (w_start) begin
            r_seen    <= '0;
            r_dup_err <= 1'b0;
        end else if (r_state == ST_COLLECT) begin
            r_seen <= w_seen_next;
            if ((w_wr_en && r_seen[image_out_index]) ||
                ((w_next == ST_DONE) && !(&w_seen_next))) begin
                r_dup_err <= 1'b1;
            end
        end
    end

    assign dup_err = r_dup_err;
`else
    assign dup_err = 1'b0;
`endif

    ise_host_result_buf u_result_buf (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (w_wr_en),
        .i_wr_addr (r_slot),
        .i_wr_data ({color_index, image_out_index}),
        .i_rd_addr (rd_addr),
        .o_rd_data (w_rd_data)
    );

    assign mem_addr       = {r_fetch_img, r_fetch_pix};
    assign ise_rst        = r_ise_rst;
    assign image_in_index = r_img;
    assign pixel_in       = r_pixel;
    assign rd_color       = w_rd_data[SLOT_W-1:IMG_W];
    assign rd_index       = w_rd_data[IMG_W-1:0];
    assign done           = (r_state == ST_DONE);
    assign sync_err       = r_sync_err;
    assign timeout_err    = r_tmo_err;

endmodule

// File: doc/ise_host.md
ISE_HOST -- requirements
Module: ise_host

Interface
REQ-001 SHALL have ports clk (in, 1, clock) and reset (in, 1, asynchronous active-high reset); single clock domain.
REQ-002 SHALL have start (in, 1): pulse; begins one 32-image run when in IDLE, ignored otherwise.
REQ-003 SHALL have mem_addr (out, 19, {image[4:0], pixel[13:0]}) and mem_rdata (in, 24, {R,G,B}); the external ROM returns data one cycle after the address.
REQ-004 SHALL have engine-side outputs ise_rst (out, 1, engine reset), image_in_index (out, 5) and pixel_in (out, 24).
REQ-005 SHALL have engine-side inputs busy (in, 1), out_valid (in, 1), color_index (in, 2) and image_out_index (in, 5).
REQ-006 SHALL have rd_addr (in, 5), rd_color (out, 2) and rd_index (out, 5): combinational read of the result buffer.
REQ-007 SHALL have done (out, 1), sync_err (out, 1), timeout_err (out, 1) and dup_err (out, 1); all error flags are sticky until the next start.

Function
REQ-008 SHALL implement states IDLE, PREFETCH, STREAM, GAP, COLLECT, DONE.
REQ-009 IDLE: ise_rst=1; on start -> PREFETCH, clearing the error flags, done, and the image/pixel counters.
REQ-010 PREFETCH: SHALL last 2 cycles, issuing mem_addr for pixel 0 of image 0; ise_rst stays 1.
REQ-011 pixel_in SHALL be a register loaded from mem_rdata; ise_rst SHALL fall on the same edge at which pixel_in first holds pixel 0.
REQ-012 STREAM: SHALL present one new pixel per cycle for exactly 16384 consecutive cycles; image_in_index equals the current image number.
REQ-013 GAP: SHALL last exactly 1 cycle after pixel 16383, during which busy is expected to be 1. Addresses SHALL lead by 2 cycles, so that pixel 0 of the next image is presented on the cycle after GAP.
REQ-014 If busy differs from its expected value in any STREAM or GAP cycle, sync_err SHALL be set; streaming continues.
REQ-015 After the GAP for image 31 -> COLLECT. pixel_in and image_in_index SHALL hold their last values.
REQ-016 COLLECT: SHALL write {color_index, image_out_index} into result slot k on each of the first 32 out_valid cycles (k=0..31), then -> DONE. Later out_valid cycles SHALL be ignored.
REQ-017 If out_valid is not seen within 1023 cycles of entering COLLECT, timeout_err SHALL be set and the FSM SHALL go -> DONE.
REQ-018 DONE: done=1 and ise_rst=1; on start the FSM SHALL behave as in IDLE; otherwise it SHALL stay in DONE.
REQ-019 The pixel counter SHALL be 14 bits and wrap from 16383 to 0; the image counter SHALL be 5 bits and saturate at 31 for the run.
REQ-020 Within one COLLECT, result slot k SHALL only be written once.

Reset
REQ-021 On reset the FSM SHALL be in IDLE; ise_rst=1; pixel_in=0, image_in_index=0, mem_addr=0; done and all error flags 0; the result buffer is cleared to 0.
REQ-022 Reset asserted mid-run SHALL abort immediately; no partial results are retained.

Configuration
REQ-023 With ISE_HOST_CHECK_EN defined, a 32-bit seen-bitmap SHALL set dup_err if any image_out_index repeats within a COLLECT, or if any index is missing at DONE.
REQ-024 Without ISE_HOST_CHECK_EN, the bitmap SHALL be absent and dup_err SHALL be tied to 0.

Structure
REQ-025 Package ise_pkg SHALL hold PIX_PER_IMG=16384, NUM_IMG=32, COLLECT_TIMEOUT=1023, color codes R=0/G=1/B=2, and the host state encoding.
REQ-026 The result storage SHALL be the sub-module ise_host_result_buf: 32x7 registers, with a write port and a combinational read port.

Verification
REQ-027 Reset, then start with a model engine: first pixel_in is ROM[0] on the ise_rst falling edge; image 1 pixel 0 appears 16385 cycles later; done rises after 32 collected results.
REQ-028 Model engine raises busy one cycle early on image 3 -> sync_err=1; the run still completes with done=1.
REQ-029 Engine returns out_valid never -> timeout_err=1 exactly 1023 cycles after COLLECT entry; done=1.
REQ-030 Engine returns indices 31..0 with colors alternating R,G -> rd_addr=0 reads {R,31}; rd_addr=31 reads {G,0}; out_valid held high for 40 cycles writes only 32 slots.
REQ-031 With ISE_HOST_CHECK_EN, index 5 returned twice -> dup_err=1; without the macro the same stimulus -> dup_err=0.
REQ-032 Reset pulsed at pixel 8000 of image 2 -> next cycle IDLE, ise_rst=1, result buffer all 0; a new start runs from image 0.
